// File: rtl/strobe_sync2.sv
// Purpose: two independent channels that synchronise an async strobe, glitch-filter it,
//          and turn qualified edges into pending/overrun flags plus an event counter.
// Latency: input stable before edge 1 -> LVL/PEND/CNT update on edge 2+FILTER; no backpressure
//          (events are never stalled, a new event while PEND is set raises sticky OVF).
module strobe_sync2 #(
    parameter int FILTER    = 3,     // consecutive disagreeing cycles before LVL flips (1..15)
    parameter int CNT_W     = 8,     // event counter width
    parameter bit EDGE_BOTH = 1'b0   // 0: rising LVL only is an event, 1: both directions
) (
    input  logic             MasterClock,
    input  logic             RESETL,
    input  logic             I1,
    input  logic             I2,
    input  logic             ACK1,
    input  logic             ACK2,
    output logic             LVL1,
    output logic             LVL2,
    output logic             PEND1,
    output logic             PEND2,
    output logic             OVF1,
    output logic             OVF2,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2
);

    // Filter counter value on which the next disagreeing sample flips LVL.
    localparam logic [3:0] FC_LAST = 4'(FILTER - 1);

    logic [1:0]       strb_w;
    logic [1:0]       ack_w;
    logic [1:0]       lvl_w;
    logic [1:0]       pend_w;
    logic [1:0]       ovf_w;
    logic [CNT_W-1:0] cnt_w [2];

    assign strb_w = {I2, I1};
    assign ack_w  = {ACK2, ACK1};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        logic             lvl_q;
        logic             lvl_d;
        logic [3:0]       fc_q;
        logic [3:0]       fc_d;
        logic             pend_q;
        logic             pend_d;
        logic             ovf_q;
        logic             ovf_d;
        logic             evt;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Filter decision, event detection and the flag/counter next state.
        always_comb begin
            lvl_d = lvl_q;
            fc_d  = fc_q + 4'd1;
            evt   = 1'b0;
            if (s2_q == lvl_q) begin
                // Agreement breaks the run; the count restarts from zero.
                fc_d = 4'd0;
            end else if (fc_q == FC_LAST) begin
                lvl_d = s2_q;
                fc_d  = 4'd0;
                evt   = EDGE_BOTH || s2_q;
            end

            // A new event outranks a same-edge acknowledge.
            pend_d = evt | (pend_q & ~ack_w[c]);

            // Overrun is set by an unacknowledged event on top of a pending one and
            // is cleared only by an acknowledge that is not racing a new event.
            ovf_d = ovf_q;
            if (evt && pend_q && !ack_w[c]) begin
                ovf_d = 1'b1;
            end else if (ack_w[c] && !evt) begin
                ovf_d = 1'b0;
            end

            cnt_d = cnt_q + CNT_W'(evt);
        end

        // Synchroniser chain and all per-channel state.
        always_ff @(posedge MasterClock or negedge RESETL) begin
            if (!RESETL) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                lvl_q  <= 1'b0;
                fc_q   <= 4'd0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
                cnt_q  <= '0;
            end else begin
                s1_q   <= strb_w[c];
                s2_q   <= s1_q;
                lvl_q  <= lvl_d;
                fc_q   <= fc_d;
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
                cnt_q  <= cnt_d;
            end
        end

        assign lvl_w[c]  = lvl_q;
        assign pend_w[c] = pend_q;
        assign ovf_w[c]  = ovf_q;
        assign cnt_w[c]  = cnt_q;
    end

    assign LVL1  = lvl_w[0];
    assign LVL2  = lvl_w[1];
    assign PEND1 = pend_w[0];
    assign PEND2 = pend_w[1];
    assign OVF1  = ovf_w[0];
    assign OVF2  = ovf_w[1];
    assign CNT1  = cnt_w[0];
    assign CNT2  = cnt_w[1];

endmodule
